// File: rtl/alioth_wb_pkg.sv
// Shared writeback definitions: source indices, default widths and the per-source request record.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 8
`endif

package alioth_wb_pkg;

    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_MUL = 1;
    localparam int unsigned WB_SRC_DIV = 2;
    localparam int unsigned WB_SRC_LSU = 3;
    localparam int unsigned WB_NUM_SRC = 4;

    localparam int unsigned WB_DW = `REG_DATA_WIDTH;
    localparam int unsigned WB_AW = `REG_ADDR_WIDTH;
    localparam int unsigned WB_CW = `COMMIT_ID_WIDTH;

    typedef struct packed {
        logic [WB_AW-1:0] waddr;
        logic [WB_DW-1:0] wdata;
        logic [WB_CW-1:0] commit_id;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arb.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping modulo N.
module wb_rr_arb #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 hold,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any_gnt
);

    logic [$clog2(N)-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = $clog2(N)'((32'(ptr) + k) % N);
            if (!any_gnt && !hold && req[idx]) begin
                any_gnt = 1'b1;
                gnt_idx = idx;
            end
        end
        if (any_gnt) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: one execution-unit result per cycle onto the RF write and commit ports.
module exu_wb_arb
    import alioth_wb_pkg::*;
#(
    parameter int unsigned NUM_SRC = WB_NUM_SRC,
    parameter int unsigned DW      = WB_DW,
    parameter int unsigned AW      = WB_AW,
    parameter int unsigned CW      = WB_CW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    src_valid_i,
    input  logic [NUM_SRC*DW-1:0] src_wdata_i,
    input  logic [NUM_SRC*AW-1:0] src_waddr_i,
    input  logic [NUM_SRC*CW-1:0] src_commit_id_i,
    input  logic                  hold_i,
    output logic [NUM_SRC-1:0]    src_ready_o,
    output logic                  rf_we_o,
    output logic [AW-1:0]         rf_waddr_o,
    output logic [DW-1:0]         rf_wdata_o,
    output logic                  commit_valid_o,
    output logic [CW-1:0]         commit_id_o,
    output logic [31:0]           conflict_cnt_o
);

    localparam int unsigned PW = $clog2(NUM_SRC);

    wb_req_t              req [NUM_SRC];
    wb_req_t              out_q;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        gnt_idx;
    logic [NUM_SRC-1:0]   gnt;
    logic                 any_gnt;
    logic                 we_q, cv_q;
    logic [31:0]          cnt_q;
    logic                 conflict;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            req[i].waddr     = src_waddr_i[i*AW +: AW];
            req[i].wdata     = src_wdata_i[i*DW +: DW];
            req[i].commit_id = src_commit_id_i[i*CW +: CW];
        end
    end

    // Reset is folded into hold so no source retires a result that the output register drops.
    wb_rr_arb #(
        .N(NUM_SRC)
    ) u_rr (
        .req     (src_valid_i),
        .ptr     (ptr_q),
        .hold    (hold_i | ~rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign src_ready_o = gnt;
    assign conflict    = ($countones(src_valid_i) > 1) && !hold_i;

    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) begin
            ptr_d = (gnt_idx == PW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            out_q <= '0;
            we_q  <= 1'b0;
            cv_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cv_q  <= any_gnt;
            we_q  <= any_gnt && (req[gnt_idx].waddr != '0);
            if (any_gnt) out_q <= req[gnt_idx];
            if (conflict && (cnt_q != '1)) cnt_q <= cnt_q + 32'd1;
        end
    end

    assign rf_we_o        = we_q;
    assign commit_valid_o = cv_q;
    assign rf_waddr_o     = out_q.waddr;
    assign rf_wdata_o     = out_q.wdata;
    assign commit_id_o    = out_q.commit_id;
    assign conflict_cnt_o = cnt_q;

endmodule
